// File: rtl/sub8_serial.sv
// rtl/sub8_serial.sv - bit-serial multi-cycle subtractor, one bit per clock
//
// Purpose:
//   Computes d = a - b - bi with a single full-adder cell. The cell is fed
//   a, ~b and a carry-in of ~bi. It resolves one bit per clock, LSB first,
//   under a start/busy/done handshake. The result registers are written only
//   on the SHIFT->DONE edge and hold until the next completion or a reset.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only in IDLE
//   a      in   WIDTH  minuend, captured on the accepted start edge
//   b      in   WIDTH  subtrahend, captured on the accepted start edge
//   bi     in   1      borrow-in, captured on the accepted start edge
//   busy   out  1      high while shifting
//   done   out  1      one-cycle completion pulse
//   d      out  WIDTH  difference mod 2^WIDTH
//   bo     out  1      borrow-out (a < b + bi, unsigned)
//   ovf    out  1      signed two's-complement overflow
//   zero   out  1      d == 0

module sub8_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Full-adder cell on the current LSBs; rb already holds ~b.
  logic             sum_bit;
  logic             carry_out;
  logic [WIDTH-1:0] rd_shift;

  always_comb begin
    sum_bit   = ra_q[0] ^ rb_q[0] ^ c_q;
    carry_out = (ra_q[0] & rb_q[0]) | (ra_q[0] & c_q) | (rb_q[0] & c_q);
    rd_shift  = {sum_bit, rd_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rd_d    = rd_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    d_d     = d_q;
    bo_d    = bo_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          ra_d    = a;
          rb_d    = ~b;
          c_d     = ~bi;
          cnt_d   = '0;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
        end
      end
      S_SHIFT: begin
        ra_d  = {1'b0, ra_q[WIDTH-1:1]};
        rb_d  = {1'b0, rb_q[WIDTH-1:1]};
        rd_d  = rd_shift;
        c_d   = carry_out;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          d_d     = rd_shift;
          // A final carry of 1 means no borrow was needed.
          bo_d    = ~carry_out;
          ovf_d   = (a_msb_q != b_msb_q) && (rd_shift[WIDTH-1] != a_msb_q);
          zero_d  = (rd_shift == '0);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      rd_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rd_q    <= rd_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign d    = d_q;
  assign bo   = bo_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_sub8_serial.sv
// tb/tb_sub8_serial.sv - directed and randomised checks of sub8_serial

module tb_sub8_serial;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;
  logic         ovf;
  logic         zero;

  int n_checks = 0;
  int n_errors = 0;

  sub8_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo),
    .ovf   (ovf),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one subtraction and checks handshake timing plus all results
  // against plain integer arithmetic.
  task automatic do_op(input string tag, input logic [W-1:0] oa,
                       input logic [W-1:0] ob, input logic obi);
    int           diff;
    logic [W-1:0] exp_d;
    logic         exp_bo;
    logic         exp_ovf;
    int           n;
    int           busy_n;
    bit           got;

    diff    = int'(oa) - int'(ob) - int'(obi);
    exp_d   = diff[W-1:0];
    exp_bo  = (diff < 0);
    exp_ovf = (oa[W-1] != ob[W-1]) && (exp_d[W-1] != oa[W-1]);

    a = oa; b = ob; bi = obi; start = 1'b1;
    step();
    start = 1'b0;
    // Operands are scrambled after acceptance; the result must not notice.
    a = W'($urandom); b = W'($urandom); bi = 1'($urandom);
    n = 0; busy_n = 0; got = 1'b0;
    while (!got && n < 20) begin
      if (busy) busy_n++;
      step();
      n++;
      if (done) got = 1'b1;
    end
    check({tag, " latency"}, 32'(n), 32'(W));
    check({tag, " busy_cycles"}, 32'(busy_n), 32'(W));
    check({tag, " busy_at_done"}, 32'(busy), 32'(0));
    check({tag, " d"}, 32'(d), 32'(exp_d));
    check({tag, " bo"}, 32'(bo), 32'(exp_bo));
    check({tag, " ovf"}, 32'(ovf), 32'(exp_ovf));
    check({tag, " zero"}, 32'(zero), 32'(exp_d == '0));
    step();
    check({tag, " done_pulse_len"}, 32'(done), 32'(0));
    check({tag, " d_hold"}, 32'(d), 32'(exp_d));
  endtask

  initial begin
    int busy_n;
    int done_n;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bi = 1'b0;
    step();
    step();
    check("reset busy", 32'(busy), 32'(0));
    check("reset done", 32'(done), 32'(0));
    check("reset d", 32'(d), 32'(0));
    check("reset flags", 32'({bo, ovf, zero}), 32'(0));
    rst_n = 1'b1;
    step();

    do_op("t1", 8'd100, 8'd37, 1'b0);
    do_op("t2a", 8'd5, 8'd9, 1'b0);
    do_op("t2b", 8'd0, 8'd0, 1'b1);
    do_op("t3a", 8'h80, 8'h01, 1'b0);
    do_op("t3b", 8'h7F, 8'hFF, 1'b0);
    do_op("t4a", 8'h2A, 8'h2A, 1'b0);
    do_op("t4b", 8'h2A, 8'h2A, 1'b1);

    // Start pulses during SHIFT and during DONE must both be ignored.
    a = 8'd3; b = 8'd1; bi = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 14; i++) begin
      if (busy) busy_n++;
      if (done) done_n++;
      if (i == 2) begin
        start = 1'b1; a = 8'd200; b = 8'd50; bi = 1'b0;
      end else if (done) begin
        start = 1'b1; a = 8'd90; b = 8'd10; bi = 1'b0;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check("t5 busy_cycles", 32'(busy_n), 32'(W));
    check("t5 done_count", 32'(done_n), 32'(1));
    check("t5 d", 32'(d), 32'(1));
    check("t5 idle", 32'({busy, done}), 32'(0));

    // Reset mid-operation aborts and clears the held result.
    a = 8'd50; b = 8'd7; bi = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    check("t6 busy", 32'(busy), 32'(0));
    check("t6 d", 32'(d), 32'(0));
    check("t6 flags", 32'({done, bo, ovf, zero}), 32'(0));
    step();
    rst_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) done_n++;
    end
    check("t6 no_done", 32'(done_n), 32'(0));
    do_op("t6 after", 8'd50, 8'd7, 1'b0);

    for (int i = 0; i < 24; i++) begin
      do_op("rand", W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
